// File: rtl/gym_pkg.sv
// Shared types and key codes for the gym character mover.
package gym_pkg;

    typedef enum logic [1:0] {
        DOWN  = 2'd0,
        UP    = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TURN = 2'd1,
        S_WALK = 2'd2
    } state_t;

    // USB HID usage codes for the WASD cluster
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

endpackage

// File: rtl/gymBoundsChecker.sv
// Wall detector for the gym room: flags when the sprite faces a wall it touches.
module gymBoundsChecker #(
    parameter int LEFT_WALL  = 160,
    parameter int RIGHT_WALL = 448,
    parameter int TOP_WALL   = 282,
    parameter int BOT_WALL   = 363
) (
    input  logic [9:0] charxcurrpos,
    input  logic [9:0] charycurrpos,
    input  logic [1:0] direction,
    output logic       atBounds
);

    always_comb begin
        atBounds = 1'b0;
        case (direction)
            2'd0:    atBounds = (charycurrpos >= 10'(BOT_WALL));
            2'd1:    atBounds = (charycurrpos <= 10'(TOP_WALL));
            2'd2:    atBounds = (charxcurrpos <= 10'(LEFT_WALL));
            default: atBounds = (charxcurrpos >= 10'(RIGHT_WALL));
        endcase
    end

endmodule

// File: rtl/gym_key_decoder.sv
// Maps a held HID keycode onto a walk direction; anything else is no request.
module gym_key_decoder
    import gym_pkg::*;
(
    input  logic [7:0] keycode_i,
    output logic       valid_o,
    output dir_t       dir_o
);

    always_comb begin
        valid_o = 1'b1;
        dir_o   = DOWN;
        case (keycode_i)
            KEY_S:   dir_o = DOWN;
            KEY_W:   dir_o = UP;
            KEY_A:   dir_o = LEFT;
            KEY_D:   dir_o = RIGHT;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/gym_char_mover.sv
// Sprite walk controller: one pixel per frame tick, steps of STEP_LEN pixels,
// with a one-cycle TURN so the external wall flag can follow a new facing.
module gym_char_mover
    import gym_pkg::*;
#(
    parameter int START_X  = 304,
    parameter int START_Y  = 300,
    parameter int STEP_LEN = 16,
    parameter int X_MAX    = 608,
    parameter int Y_MAX    = 448
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic       atBounds,
    output logic [1:0] direction,
    output logic [9:0] charxcurrpos,
    output logic [9:0] charycurrpos,
    output logic       walking,
    output logic [1:0] anim_frame
);

    localparam int CNT_W = (STEP_LEN > 16) ? $clog2(STEP_LEN) : 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_LEN - 1);

    state_t           state_q, state_d;
    dir_t             dir_q, dir_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             walk_q, walk_d;
    logic [1:0]       anim_q, anim_d;
    logic             key_vld, at_limit;
    dir_t             key_dir;

    gym_key_decoder u_dec (
        .keycode_i (keycode),
        .valid_o   (key_vld),
        .dir_o     (key_dir)
    );

    // Screen clamp, independent of the room walls reported by atBounds
    always_comb begin
        case (dir_q)
            DOWN:    at_limit = (y_q >= 10'(Y_MAX));
            UP:      at_limit = (y_q == 10'd0);
            LEFT:    at_limit = (x_q == 10'd0);
            default: at_limit = (x_q >= 10'(X_MAX));
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (key_vld) begin
                    dir_d   = key_dir;
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                state_d = S_WALK;
                cnt_d   = '0;
            end
            S_WALK: begin
                if (frame_tick) begin
                    if (atBounds || at_limit) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        case (dir_q)
                            DOWN:    y_d = y_q + 10'd1;
                            UP:      y_d = y_q - 10'd1;
                            LEFT:    x_d = x_q - 10'd1;
                            default: x_d = x_q + 10'd1;
                        endcase
                        // Keys are only re-examined once a whole step is done
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            if (!key_vld) begin
                                state_d = S_IDLE;
                            end else if (key_dir != dir_q) begin
                                state_d = S_TURN;
                                dir_d   = key_dir;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        walk_d = (state_d == S_WALK);
        anim_d = walk_d ? cnt_d[3:2] : 2'd0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dir_q  <= DOWN;
            x_q    <= 10'(START_X);
            y_q    <= 10'(START_Y);
            cnt_q  <= '0;
            walk_q <= 1'b0;
            anim_q <= 2'd0;
        end else begin
            dir_q  <= dir_d;
            x_q    <= x_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
            walk_q <= walk_d;
            anim_q <= anim_d;
        end
    end

    assign direction    = dir_q;
    assign charxcurrpos = x_q;
    assign charycurrpos = y_q;
    assign walking      = walk_q;
    assign anim_frame   = anim_q;

endmodule

// File: tb/tb_gym_char_mover.sv
// Directed bench for gym_char_mover with the bounds checker closing the wall loop.
module tb_gym_char_mover;
    import gym_pkg::*;

    logic       Clk, Reset_n, frame_tick, atBounds, walking;
    logic [7:0] keycode;
    logic [1:0] direction, anim_frame;
    logic [9:0] charxcurrpos, charycurrpos;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] dir;
        logic       walk;
        logic [1:0] anim;
    } exp_t;
    exp_t sb[$];

    gym_char_mover dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_tick   (frame_tick),
        .keycode      (keycode),
        .atBounds     (atBounds),
        .direction    (direction),
        .charxcurrpos (charxcurrpos),
        .charycurrpos (charycurrpos),
        .walking      (walking),
        .anim_frame   (anim_frame)
    );

    gymBoundsChecker bounds (
        .charxcurrpos (charxcurrpos),
        .charycurrpos (charycurrpos),
        .direction    (direction),
        .atBounds     (atBounds)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d,
                        input logic w, input logic [1:0] a);
        exp_t e;
        e.x = x; e.y = y; e.dir = d; e.walk = w; e.anim = a;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".x"},    32'(charxcurrpos), 32'(e.x));
            chk({tag, ".y"},    32'(charycurrpos), 32'(e.y));
            chk({tag, ".dir"},  32'(direction),    32'(e.dir));
            chk({tag, ".walk"}, 32'(walking),      32'(e.walk));
            chk({tag, ".anim"}, 32'(anim_frame),   32'(e.anim));
        end
    endtask

    // One frame_tick every 4 Clk; returns one Clk after the tick edge
    task automatic tick();
        repeat (3) @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // Held key: n one-pixel moves, then one more tick that hits the wall
    task automatic walk_seq(input string tag, input int n, input int dx, input int dy,
                            input logic [1:0] d, input logic [9:0] x0, input logic [9:0] y0);
        int k;
        for (int i = 1; i <= n + 1; i++) begin
            k = (i <= n) ? i : n;
            push(10'(int'(x0) + dx * k), 10'(int'(y0) + dy * k), d,
                 (i <= n), (i <= n) ? 2'((i % 16) >> 2) : 2'd0);
            tick();
            sb_check($sformatf("%s[%0d]", tag, i));
        end
    endtask

    initial begin
        Reset_n    = 1'b0;
        frame_tick = 1'b0;
        keycode    = 8'h00;
        repeat (3) @(negedge Clk);
        chk("rst.x",    32'(charxcurrpos), 32'd304);
        chk("rst.y",    32'(charycurrpos), 32'd300);
        chk("rst.dir",  32'(direction),    32'd0);
        chk("rst.walk", 32'(walking),      32'd0);
        chk("rst.anim", 32'(anim_frame),   32'd0);
        Reset_n = 1'b1;

        keycode = KEY_S;
        walk_seq("S", 63, 0, 1, 2'd0, 10'd304, 10'd300);
        keycode = 8'h00;

        // Facing the bottom wall: S is absorbed, W moves off it
        keycode = KEY_S;
        push(10'd304, 10'd363, 2'd0, 1'b0, 2'd0);
        tick();
        sb_check("S_wall");
        keycode = KEY_W;
        push(10'd304, 10'd362, 2'd1, 1'b1, 2'd0);
        tick();
        sb_check("W_off");
        keycode = 8'h00;

        do_reset();
        keycode = KEY_W;
        walk_seq("W", 18, 0, -1, 2'd1, 10'd304, 10'd300);
        keycode = 8'h00;

        do_reset();
        keycode = KEY_D;
        walk_seq("D", 144, 1, 0, 2'd3, 10'd304, 10'd300);
        keycode = 8'h00;

        // Release mid-step: the step still finishes
        do_reset();
        keycode = KEY_A;
        for (int i = 1; i <= 16; i++) begin
            push(10'(304 - i), 10'd300, 2'd2, (i < 16), (i < 16) ? 2'(i >> 2) : 2'd0);
            tick();
            sb_check($sformatf("A_rel[%0d]", i));
            if (i == 5) keycode = 8'h00;
        end
        push(10'd288, 10'd300, 2'd2, 1'b0, 2'd0);
        tick();
        sb_check("A_idle");

        keycode = KEY_A;
        for (int i = 1; i <= 8; i++) begin
            push(10'(288 - i), 10'd300, 2'd2, 1'b1, 2'(i >> 2));
            tick();
            sb_check($sformatf("A2[%0d]", i));
        end
        Reset_n = 1'b0;
        #1;
        chk("midrst.x",    32'(charxcurrpos), 32'd304);
        chk("midrst.y",    32'(charycurrpos), 32'd300);
        chk("midrst.dir",  32'(direction),    32'd0);
        chk("midrst.walk", 32'(walking),      32'd0);
        chk("midrst.anim", 32'(anim_frame),   32'd0);
        keycode = 8'h00;
        @(negedge Clk);
        Reset_n = 1'b1;
        push(10'd304, 10'd300, 2'd0, 1'b0, 2'd0);
        tick();
        sb_check("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gym_char_mover.md
GYM_CHAR_MOVER -- requirements
Module: gym_char_mover

Interface
REQ-001 SHALL have parameter START_X, default 304, reset x position in pixels.
REQ-002 SHALL have parameter START_Y, default 300, reset y position in pixels.
REQ-003 SHALL have parameter STEP_LEN, default 16, pixels per walk step.
REQ-004 SHALL have parameters X_MAX and Y_MAX, defaults 608 and 448, the screen clamp limits; X_MIN and Y_MIN are fixed at 0.
REQ-005 SHALL have port Clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port Reset_n, input, 1 bit, reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port frame_tick, input, 1 bit, one-Clk-wide pulse per video frame, already synchronous to Clk.
REQ-008 SHALL have port keycode, input, 8 bits, USB HID code of the held key, 0x00 for none.
REQ-009 SHALL have port atBounds, input, 1 bit, combinational wall flag for the current direction and position, fed back from the gym bounds checker.
REQ-010 SHALL have port direction, output, 2 bits, facing: 0 down, 1 up, 2 left, 3 right.
REQ-011 SHALL have ports charxcurrpos and charycurrpos, output, 10 bits each, current sprite position.
REQ-012 SHALL have port walking, output, 1 bit, high while in WALK.
REQ-013 SHALL have port anim_frame, output, 2 bits, walk animation index.

Function
REQ-014 SHALL decode keys: 0x16 (S) down, 0x1A (W) up, 0x04 (A) left, 0x07 (D) right; any other code means no request.
REQ-015 SHALL implement the states IDLE, TURN and WALK.
REQ-016 IDLE: a valid key SHALL load direction and go to TURN on the next Clk; no key SHALL keep the FSM in IDLE.
REQ-017 TURN SHALL last exactly 1 Clk, giving atBounds one cycle to settle on the new direction, then go to WALK with step_cnt cleared.
REQ-018 WALK SHALL change state only on cycles where frame_tick is 1; with frame_tick 0, all outputs hold.
REQ-019 On a WALK tick with atBounds 1, or with the position at its clamp limit for the facing, WALK SHALL leave the position unchanged and return to IDLE (the partial step is abandoned).
REQ-020 Otherwise the tick SHALL move the position by exactly 1 pixel (down +y, up -y, left -x, right +x) and increment step_cnt.
REQ-021 When step_cnt reaches STEP_LEN-1 on a tick, the step completes and step_cnt clears; then:
- same key still held -> remain in WALK;
- different valid key -> TURN;
- no key -> IDLE.
REQ-022 Key changes or release in the middle of a step SHALL be ignored until the step completes.
REQ-023 A key for the current facing pressed while atBounds is 1 SHALL pass through TURN and WALK, then return to IDLE with no movement; an opposite key SHALL move normally.
REQ-024 anim_frame SHALL be step_cnt[3:2] while walking is 1, and 0 in IDLE and TURN.
REQ-025 Position arithmetic SHALL be 10-bit unsigned and SHALL never wrap past 0 or past X_MAX/Y_MAX.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 Reset_n low SHALL force immediately: FSM IDLE, charxcurrpos START_X, charycurrpos START_Y, direction 0, step_cnt 0, walking 0, anim_frame 0.
REQ-028 Reset mid-step SHALL discard the step; after release, motion SHALL restart only on a new IDLE key decode.

Structure
REQ-029 Package gym_pkg SHALL hold the dir_t enum (DOWN=0, UP=1, LEFT=2, RIGHT=3), the four keycode constants, and the state enum.
REQ-030 The keycode-to-direction decode SHALL be a sub-module gym_key_decoder (keycode in; valid and dir_t out).
REQ-031 The bench SHALL instantiate gymBoundsChecker outside the mover to close the atBounds loop.

Verification
REQ-032 Hold S from reset (304,300), one frame_tick every 4 Clk -> y rises 1 per tick and stops at 363 after 63 ticks; walking falls; x stays 304.
REQ-033 Hold D from reset -> x reaches 448 after 144 ticks (9 full steps), then IDLE with direction 3.
REQ-034 Hold W from reset -> one full step to y=284, then stop at 282 after 2 more ticks; anim_frame shows 0,1,2,3 across the first step.
REQ-035 At y=363, press S -> no movement, back to IDLE within 2 ticks; then press W -> y=362 on the first tick.
REQ-036 Hold A, release at tick 5 -> movement continues to tick 16 (x=288), then IDLE; assert Reset_n low at tick 8 of a new step -> position returns to (304,300) immediately.
